mpd_tx_engine: RTL and testbench
================================

// Module: mpd_tx_engine
// PURPOSE
//   Transmit half of the packet dispatcher. Accepts per-slot firewall verdicts
//   {slot, unsafe}, buffers them, and for safe slots commands the PRT to replay
//   the stored frame, streaming it byte-wise to the Ethernet MAC with last-byte
//   marking. Every slot is then freed with an invalidate to the PRT. Unsafe
//   slots are invalidated without transmission.
// PARAMETERS
//   DATA_WIDTH  8     byte lane width
//   SLOT_W      2     slot tag width (2**SLOT_W PRT slots)
//   QDEPTH      4     verdict queue depth (power of 2, >=2)
//   MAX_FRAME   1500  max bytes sent per frame; longer frames are truncated
//   LEN_W       11    byte counter width (2**LEN_W > MAX_FRAME)
// PORTS
//   clk             in   1           clock
//   reset           in   1           synchronous, active-high reset
//   verdict_valid   in   1           firewall verdict present
//   verdict_ready   out  1           verdict accepted when valid&ready
//   verdict_slot    in   SLOT_W      PRT slot of judged frame
//   verdict_unsafe  in   1           1 = drop, 0 = transmit
//   prt_tx_start    out  1           1-cycle pulse: PRT begins replay of prt_tx_slot
//   prt_tx_slot     out  SLOT_W      slot being replayed/invalidated
//   prt_rd_valid    in   1           PRT byte valid
//   prt_rd_data     in   DATA_WIDTH  PRT byte
//   prt_rd_last     in   1           final byte of stored frame
//   prt_rd_ready    out  1           engine accepts PRT byte
//   prt_inv         out  1           1-cycle pulse: free slot prt_tx_slot
//   tx_valid        out  1           MAC byte valid
//   tx_data         out  DATA_WIDTH  MAC byte
//   tx_last         out  1           last byte of frame
//   tx_ready        in   1           MAC accepts byte
//   frame_sent      out  1           1-cycle pulse: frame fully sent and slot freed
//   oversize_err    out  1           1-cycle pulse: frame truncated at MAX_FRAME
//   sent_cnt        out  16          frames sent, saturating
//   drop_cnt        out  16          unsafe frames dropped, saturating
// BEHAVIOUR
//   Reset: all outputs 0, queue empty, counters 0, FSM IDLE. Reset mid-frame aborts;
//     PRT shares reset, so no invalidate is issued.
//   Queue: FIFO of {slot,unsafe}; verdict_ready = !full. Push and pop in the same
//     cycle both take effect, count unchanged. Pop happens only in IDLE.
//   FSM:
//     IDLE   : queue non-empty -> pop head into cur_slot/cur_unsafe;
//              unsafe -> INVAL, safe -> START. Empty -> stay.
//     START  : prt_tx_start=1, prt_tx_slot=cur_slot for exactly 1 cycle;
//              clear byte_cnt -> STREAM.
//     STREAM : one-entry output register; prt_rd_ready = !tx_valid | tx_ready.
//              On PRT handshake: load tx_data, tx_valid=1, byte_cnt++.
//              tx_last=1 if prt_rd_last or byte_cnt==MAX_FRAME-1.
//              Accepted byte with prt_rd_last -> FLUSH.
//              Accepted byte MAX_FRAME without last -> oversize_err pulse, DRAIN.
//     DRAIN  : prt_rd_ready=1, bytes discarded (tx path untouched) until
//              prt_rd_valid&prt_rd_last -> FLUSH.
//     FLUSH  : prt_rd_ready=0; wait until tx_valid==0 -> INVAL.
//     INVAL  : prt_inv=1 with prt_tx_slot=cur_slot for 1 cycle. Safe: frame_sent=1,
//              sent_cnt++. Unsafe: drop_cnt++. -> IDLE.
//   tx_valid drops on tx handshake unless reloaded in the same cycle.
//   tx_data/tx_last hold stable while tx_valid & !tx_ready.
//   Latency: PRT byte -> tx_valid 1 cycle. Unsafe verdict accepted with queue
//     empty -> prt_inv 2 cycles later (IDLE pop, INVAL).
//   1-byte frame (last on first byte) is legal. Counters saturate at 16'hFFFF.
//   Engine never reorders: frames leave in verdict order; no per-slot dedupe.
// TESTING
//   1 safe slot 2, PRT gives 64 bytes 0x00..0x3F, tx_ready=1 -> one prt_tx_start
//     (slot 2), 64 tx bytes in order, tx_last only on 0x3F, prt_inv slot 2,
//     frame_sent=1, sent_cnt=1.
//   2 unsafe slot 1 into empty queue -> no prt_tx_start/tx_valid;
//     prt_inv slot 1 two cycles after accept; drop_cnt=1.
//   3 tx_ready pattern 1,0,1,0... on a 32-byte frame -> exactly 32 bytes, no loss
//     or duplication, data stable during stalls.
//   4 6 back-to-back verdicts with tx_ready=0 -> first popped, 4 queued,
//     verdict_ready=0 for the 6th until IDLE pops again.
//   5 MAX_FRAME=16, PRT gives 20 bytes -> 16 tx bytes, tx_last on 16th,
//     oversize_err pulse, 4 bytes drained, prt_inv issued, frame_sent=1.
//   6 reset after 10 bytes streamed -> next cycle all outputs 0, queue empty,
//     counters 0; a new verdict then runs normally.

Source files
------------

// File: rtl/mpd_tx_engine_if.sv
// Handshake bundle for the packet dispatcher transmit engine: verdict input,
// PRT replay/invalidate port and the MAC byte stream.
interface mpd_tx_engine_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SLOT_W     = 2
);
   logic                  verdict_valid;
   logic                  verdict_ready;
   logic [SLOT_W-1:0]     verdict_slot;
   logic                  verdict_unsafe;

   logic                  prt_tx_start;
   logic [SLOT_W-1:0]     prt_tx_slot;
   logic                  prt_rd_valid;
   logic [DATA_WIDTH-1:0] prt_rd_data;
   logic                  prt_rd_last;
   logic                  prt_rd_ready;
   logic                  prt_inv;

   logic                  tx_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_last;
   logic                  tx_ready;

   // master: the engine; slave: firewall, PRT and MAC seen together
   modport master (
      input  verdict_valid, verdict_slot, verdict_unsafe,
      output verdict_ready,
      output prt_tx_start, prt_tx_slot, prt_rd_ready, prt_inv,
      input  prt_rd_valid, prt_rd_data, prt_rd_last,
      output tx_valid, tx_data, tx_last,
      input  tx_ready
   );

   modport slave (
      output verdict_valid, verdict_slot, verdict_unsafe,
      input  verdict_ready,
      input  prt_tx_start, prt_tx_slot, prt_rd_ready, prt_inv,
      output prt_rd_valid, prt_rd_data, prt_rd_last,
      input  tx_valid, tx_data, tx_last,
      output tx_ready
   );
endinterface

// File: rtl/mpd_tx_engine.sv
// Transmit half of the packet dispatcher: queues firewall verdicts, replays safe
// frames from the PRT to the MAC, and frees every slot with an invalidate.
module mpd_tx_engine #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SLOT_W     = 2,
   parameter int unsigned QDEPTH     = 4,
   parameter int unsigned MAX_FRAME  = 1500,
   parameter int unsigned LEN_W      = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   mpd_tx_engine_if.master       bus,
   output logic                  frame_sent,
   output logic                  oversize_err,
   output logic [15:0]           sent_cnt,
   output logic [15:0]           drop_cnt
);
   localparam int unsigned PTR_W = $clog2(QDEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_STREAM, S_DRAIN, S_FLUSH, S_INVAL
   } state_t;

   state_t                state_q, state_d;
   logic [SLOT_W:0]       qmem_q [QDEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic                  full, empty, push, pop;

   logic [SLOT_W-1:0]     cur_slot_q, cur_slot_d;
   logic                  cur_unsafe_q, cur_unsafe_d;
   logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_last_q, tx_last_d;
   logic [15:0]           sent_q, sent_d, drop_q, drop_d;
   logic                  rd_ready, at_max;

   assign full  = (count_q == (PTR_W+1)'(QDEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.verdict_valid && !full;
   assign at_max = (byte_cnt_q == LEN_W'(MAX_FRAME - 1));

   always_ff @(posedge clk) begin
      if (push) qmem_q[wr_ptr_q] <= {bus.verdict_slot, bus.verdict_unsafe};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cur_slot_q   <= '0;
         cur_unsafe_q <= 1'b0;
         byte_cnt_q   <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         tx_last_q    <= 1'b0;
         sent_q       <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         cur_slot_q   <= cur_slot_d;
         cur_unsafe_q <= cur_unsafe_d;
         byte_cnt_q   <= byte_cnt_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         tx_last_q    <= tx_last_d;
         sent_q       <= sent_d;
         drop_q       <= drop_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_slot_d   = cur_slot_q;
      cur_unsafe_d = cur_unsafe_q;
      byte_cnt_d   = byte_cnt_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      tx_last_d    = tx_last_q;
      sent_d       = sent_q;
      drop_d       = drop_q;
      pop          = 1'b0;
      rd_ready     = 1'b0;
      bus.prt_tx_start = 1'b0;
      bus.prt_inv      = 1'b0;
      frame_sent   = 1'b0;
      oversize_err = 1'b0;

      // MAC may retire the held byte in any state; a reload below overrides this
      if (tx_valid_q && bus.tx_ready) begin
         tx_valid_d = 1'b0;
         tx_last_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               cur_slot_d   = qmem_q[rd_ptr_q][SLOT_W:1];
               cur_unsafe_d = qmem_q[rd_ptr_q][0];
               state_d      = qmem_q[rd_ptr_q][0] ? S_INVAL : S_START;
            end
         end
         S_START: begin
            bus.prt_tx_start = 1'b1;
            byte_cnt_d       = '0;
            state_d          = S_STREAM;
         end
         S_STREAM: begin
            rd_ready = !tx_valid_q || bus.tx_ready;
            if (bus.prt_rd_valid && rd_ready) begin
               tx_data_d  = bus.prt_rd_data;
               tx_valid_d = 1'b1;
               tx_last_d  = bus.prt_rd_last || at_max;
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (bus.prt_rd_last) begin
                  state_d = S_FLUSH;
               end else if (at_max) begin
                  oversize_err = 1'b1;
                  state_d      = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            rd_ready = 1'b1;
            if (bus.prt_rd_valid && bus.prt_rd_last) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (!tx_valid_q) state_d = S_INVAL;
         end
         S_INVAL: begin
            bus.prt_inv = 1'b1;
            if (cur_unsafe_q) begin
               if (drop_q != '1) drop_d = drop_q + 1'b1;
            end else begin
               frame_sent = 1'b1;
               if (sent_q != '1) sent_d = sent_q + 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.verdict_ready = !full;
   assign bus.prt_tx_slot   = cur_slot_q;
   assign bus.prt_rd_ready  = rd_ready;
   assign bus.tx_valid      = tx_valid_q;
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_last       = tx_last_q;
   assign sent_cnt          = sent_q;
   assign drop_cnt          = drop_q;
endmodule

// File: tb/tb_mpd_tx_engine.sv
// Directed bench for mpd_tx_engine: a small PRT/MAC model drives two engines
// (full-size and MAX_FRAME=16) and hand-computed expectations are checked.
module tb_mpd_tx_engine;
   localparam int unsigned DW = 8;
   localparam int unsigned SW = 2;

   logic clk = 1'b0;
   logic reset, rst_small, use_small;
   always #5 clk = ~clk;

   logic          verdict_valid, verdict_unsafe, prt_rd_valid, prt_rd_last, tx_ready;
   logic [SW-1:0] verdict_slot;
   logic [DW-1:0] prt_rd_data;

   mpd_tx_engine_if #(.DATA_WIDTH(DW), .SLOT_W(SW)) bus_a ();
   mpd_tx_engine_if #(.DATA_WIDTH(DW), .SLOT_W(SW)) bus_s ();

   assign bus_a.verdict_valid  = verdict_valid;
   assign bus_a.verdict_slot   = verdict_slot;
   assign bus_a.verdict_unsafe = verdict_unsafe;
   assign bus_a.prt_rd_valid   = prt_rd_valid;
   assign bus_a.prt_rd_data    = prt_rd_data;
   assign bus_a.prt_rd_last    = prt_rd_last;
   assign bus_a.tx_ready       = tx_ready;
   assign bus_s.verdict_valid  = verdict_valid;
   assign bus_s.verdict_slot   = verdict_slot;
   assign bus_s.verdict_unsafe = verdict_unsafe;
   assign bus_s.prt_rd_valid   = prt_rd_valid;
   assign bus_s.prt_rd_data    = prt_rd_data;
   assign bus_s.prt_rd_last    = prt_rd_last;
   assign bus_s.tx_ready       = tx_ready;

   logic        fs_a, ov_a, fs_s, ov_s;
   logic [15:0] sc_a, dc_a, sc_s, dc_s;

   mpd_tx_engine #(
      .DATA_WIDTH(DW), .SLOT_W(SW), .QDEPTH(4), .MAX_FRAME(1500), .LEN_W(11)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus_a),
      .frame_sent(fs_a), .oversize_err(ov_a), .sent_cnt(sc_a), .drop_cnt(dc_a)
   );

   mpd_tx_engine #(
      .DATA_WIDTH(DW), .SLOT_W(SW), .QDEPTH(4), .MAX_FRAME(16), .LEN_W(5)
   ) u_dut_small (
      .clk(clk), .reset(rst_small), .bus(bus_s),
      .frame_sent(fs_s), .oversize_err(ov_s), .sent_cnt(sc_s), .drop_cnt(dc_s)
   );

   logic          o_verdict_ready, o_prt_tx_start, o_prt_rd_ready, o_prt_inv;
   logic          o_tx_valid, o_tx_last, o_frame_sent, o_oversize;
   logic [SW-1:0] o_prt_tx_slot;
   logic [DW-1:0] o_tx_data;
   logic [15:0]   o_sent_cnt, o_drop_cnt;

   assign o_verdict_ready = use_small ? bus_s.verdict_ready : bus_a.verdict_ready;
   assign o_prt_tx_start  = use_small ? bus_s.prt_tx_start  : bus_a.prt_tx_start;
   assign o_prt_tx_slot   = use_small ? bus_s.prt_tx_slot   : bus_a.prt_tx_slot;
   assign o_prt_rd_ready  = use_small ? bus_s.prt_rd_ready  : bus_a.prt_rd_ready;
   assign o_prt_inv       = use_small ? bus_s.prt_inv       : bus_a.prt_inv;
   assign o_tx_valid      = use_small ? bus_s.tx_valid      : bus_a.tx_valid;
   assign o_tx_data       = use_small ? bus_s.tx_data       : bus_a.tx_data;
   assign o_tx_last       = use_small ? bus_s.tx_last       : bus_a.tx_last;
   assign o_frame_sent    = use_small ? fs_s : fs_a;
   assign o_oversize      = use_small ? ov_s : ov_a;
   assign o_sent_cnt      = use_small ? sc_s : sc_a;
   assign o_drop_cnt      = use_small ? dc_s : dc_a;

   int n_checks = 0;
   int n_err    = 0;

   int cyc, prt_len, idx, rdy_mode;
   bit prt_active, hold_q;
   logic [8:0]    hold_w;
   logic [SW:0]   vq[$];
   logic [8:0]    rx[$];
   logic [SW-1:0] start_slots[$], inv_slots[$];
   int            inv_cycs[$];
   int starts, invs, sents, overs, stall_err, stalls, tx_seen, acc_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      rx.delete(); start_slots.delete(); inv_slots.delete(); inv_cycs.delete();
      starts = 0; invs = 0; sents = 0; overs = 0;
      stall_err = 0; stalls = 0; tx_seen = 0;
   endtask

   // One clock: drive the models just after the edge, then observe and account handshakes
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      verdict_valid = (vq.size() != 0);
      if (verdict_valid) {verdict_slot, verdict_unsafe} = vq[0];
      else               {verdict_slot, verdict_unsafe} = '0;
      prt_rd_valid = prt_active && (idx < prt_len);
      prt_rd_data  = 8'(idx);
      prt_rd_last  = prt_rd_valid && (idx == prt_len - 1);
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = cyc[0];
         default: tx_ready = 1'b0;
      endcase
      #1;
      if (verdict_valid && o_verdict_ready) begin
         void'(vq.pop_front());
         acc_cyc = cyc;
      end
      if (o_prt_tx_start) begin
         starts++;
         start_slots.push_back(o_prt_tx_slot);
         prt_active = 1'b1;
         idx = 0;
      end
      if (o_prt_inv) begin
         invs++;
         inv_slots.push_back(o_prt_tx_slot);
         inv_cycs.push_back(cyc);
      end
      if (o_frame_sent) sents++;
      if (o_oversize)   overs++;
      if (o_tx_valid)   tx_seen++;
      if (hold_q && (!o_tx_valid || {o_tx_last, o_tx_data} !== hold_w)) stall_err++;
      hold_q = o_tx_valid && !tx_ready;
      hold_w = {o_tx_last, o_tx_data};
      if (hold_q) stalls++;
      if (o_tx_valid && tx_ready) rx.push_back({o_tx_last, o_tx_data});
      if (prt_rd_valid && o_prt_rd_ready) begin
         if (prt_rd_last) prt_active = 1'b0;
         idx++;
      end
   endtask

   task automatic run_until_inv(input string tag, input int target, input int budget);
      int n = 0;
      while (invs < target && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_inv_count"}, invs, target);
   endtask

   task automatic check_frame(input string tag, input int n, input int last_pos);
      check({tag, "_len"}, rx.size(), n);
      for (int i = 0; i < n && i < rx.size(); i++)
         check({tag, "_byte"}, rx[i], {(i == last_pos), 8'(i)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rst_small = 1'b1; use_small = 1'b0;
      verdict_valid = 1'b0; verdict_slot = '0; verdict_unsafe = 1'b0;
      prt_rd_valid = 1'b0; prt_rd_data = '0; prt_rd_last = 1'b0; tx_ready = 1'b0;
      cyc = 0; prt_len = 0; idx = 0; rdy_mode = 0; prt_active = 1'b0;
      hold_q = 1'b0; hold_w = '0; acc_cyc = 0;
      clear_stats();
      repeat (3) cycle();
      reset = 1'b0;
      cycle();

      // reset state
      check("rst_tx_valid",   o_tx_valid, 0);
      check("rst_tx_data",    o_tx_data, 0);
      check("rst_tx_last",    o_tx_last, 0);
      check("rst_prt_start",  o_prt_tx_start, 0);
      check("rst_prt_inv",    o_prt_inv, 0);
      check("rst_prt_ready",  o_prt_rd_ready, 0);
      check("rst_counters",   {o_sent_cnt, o_drop_cnt}, 0);
      check("rst_verdict_rdy", o_verdict_ready, 1);

      // 1: safe slot 2, 64-byte frame, MAC always ready
      clear_stats(); prt_len = 64;
      vq.push_back({2'd2, 1'b0});
      run_until_inv("t1", 1, 400);
      check("t1_starts", starts, 1);
      check("t1_start_slot", start_slots.size() != 0 ? 32'(start_slots[0]) : 32'hFFFF_FFFF, 2);
      check_frame("t1", 64, 63);
      check("t1_inv_slot", inv_slots.size() != 0 ? 32'(inv_slots[0]) : 32'hFFFF_FFFF, 2);
      check("t1_frame_sent", sents, 1);
      cycle();
      check("t1_sent_cnt", o_sent_cnt, 1);

      // 2: unsafe slot 1 into empty queue
      clear_stats();
      vq.push_back({2'd1, 1'b1});
      run_until_inv("t2", 1, 20);
      check("t2_starts", starts, 0);
      check("t2_tx_valid_seen", tx_seen, 0);
      check("t2_inv_latency", inv_cycs.size() != 0 ? 32'(inv_cycs[0] - acc_cyc) : 32'hFFFF_FFFF, 2);
      check("t2_inv_slot", inv_slots.size() != 0 ? 32'(inv_slots[0]) : 32'hFFFF_FFFF, 1);
      check("t2_frame_sent", sents, 0);
      cycle();
      check("t2_drop_cnt", o_drop_cnt, 1);
      check("t2_sent_cnt", o_sent_cnt, 1);

      // 3: alternating MAC ready on a 32-byte frame
      clear_stats(); prt_len = 32; rdy_mode = 1;
      vq.push_back({2'd3, 1'b0});
      run_until_inv("t3", 1, 400);
      check_frame("t3", 32, 31);
      check("t3_stall_stable", stall_err, 0);
      check("t3_stalls_seen", stalls > 0, 1);
      cycle();
      check("t3_sent_cnt", o_sent_cnt, 2);

      // 4: six back-to-back verdicts while the MAC is stalled
      clear_stats(); prt_len = 4; rdy_mode = 2;
      for (int i = 0; i < 6; i++) vq.push_back({SW'(i % 4), 1'b0});
      repeat (20) cycle();
      check("t4_starts_stalled", starts, 1);
      check("t4_pending", vq.size(), 1);
      check("t4_verdict_ready", o_verdict_ready, 0);
      rdy_mode = 0;
      run_until_inv("t4", 6, 600);
      check("t4_pending_end", vq.size(), 0);
      check("t4_starts", starts, 6);
      for (int i = 0; i < 6 && i < start_slots.size(); i++)
         check("t4_order", start_slots[i], i % 4);
      check("t4_sixth_accept", inv_cycs.size() != 0 ? 32'(acc_cyc - inv_cycs[0]) : 32'hFFFF_FFFF, 2);
      check("t4_bytes", rx.size(), 24);
      check("t4_frame_sent", sents, 6);
      cycle();
      check("t4_sent_cnt", o_sent_cnt, 8);

      // 5: MAX_FRAME=16 engine, 20-byte stored frame
      reset = 1'b1; rst_small = 1'b0; use_small = 1'b1;
      cycle();
      clear_stats(); prt_len = 20;
      vq.push_back({2'd0, 1'b0});
      run_until_inv("t5", 1, 200);
      check_frame("t5", 16, 15);
      check("t5_oversize", overs, 1);
      check("t5_drained", idx, 20);
      check("t5_frame_sent", sents, 1);
      cycle();
      check("t5_sent_cnt", o_sent_cnt, 1);

      // 6: reset mid-frame, then a fresh frame
      rst_small = 1'b1; use_small = 1'b0;
      cycle();
      reset = 1'b0;
      clear_stats(); prt_len = 8;
      vq.push_back({2'd3, 1'b0});
      run_until_inv("t6a", 1, 200);
      cycle();
      check("t6_sent_before", o_sent_cnt, 1);
      clear_stats(); prt_len = 40;
      for (int i = 0; i < 3; i++) vq.push_back({SW'(i), 1'b0});
      for (int n = 0; n < 200 && rx.size() < 10; n++) cycle();
      check("t6_streamed", rx.size(), 10);
      reset = 1'b1;
      vq.delete(); prt_active = 1'b0; idx = 0; hold_q = 1'b0;
      cycle();
      reset = 1'b0;
      check("t6_tx_valid",  o_tx_valid, 0);
      check("t6_tx_data",   o_tx_data, 0);
      check("t6_prt_ready", o_prt_rd_ready, 0);
      check("t6_prt_inv",   o_prt_inv, 0);
      check("t6_counters",  {o_sent_cnt, o_drop_cnt}, 0);
      clear_stats();
      repeat (5) cycle();
      check("t6_queue_empty", starts, 0);
      check("t6_no_inv", invs, 0);
      prt_len = 5;
      vq.push_back({2'd1, 1'b0});
      run_until_inv("t6b", 1, 200);
      check_frame("t6b", 5, 4);
      check("t6_inv_slot", inv_slots.size() != 0 ? 32'(inv_slots[0]) : 32'hFFFF_FFFF, 1);
      cycle();
      check("t6_sent_cnt", o_sent_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
